// File: rtl/ula_sequencial.sv
// Handshaked sequential ALU front-end: valid/ready command in, registered result/flags out.
// Define ULA_MUL_EN to build the iterative shift-add multiplier for ctrl=111.
module ula_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] scr0,
    input  logic [WIDTH-1:0] scr1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Single-cycle datapath, driven only by the captured operands
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   shr;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    assign amt  = b[SHW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // The extra bit catches the last bit shifted out; it stays 0 for a zero shift
    assign shl  = {1'b0, a} << amt;
    assign shr  = {a, 1'b0} >> amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            3'b000: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
            3'b001: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a | b;
            3'b100: alu_res = a ^ b;
            3'b101: begin alu_res = shl[WIDTH-1:0];  alu_c = shl[WIDTH];  end
            3'b110: begin alu_res = shr[WIDTH:1];    alu_c = shr[0];      end
            default: begin alu_res = '0; alu_c = 1'b0; end
        endcase
    end

`ifdef ULA_MUL_EN
    // acc = {partial product, remaining multiplier bits}; one bit retired per cycle
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] acc_step;

    assign hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    assign acc_step = {hi_sum, acc[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            a         <= '0;
            b         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
`ifdef ULA_MUL_EN
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= ctrl;
                        a        <= scr0;
                        b        <= scr1;
                        in_ready <= 1'b0;
                        state    <= EXEC;
`ifdef ULA_MUL_EN
                        if (ctrl == 3'b111) begin
                            acc   <= {{WIDTH{1'b0}}, scr1};
                            cnt   <= SHW'(WIDTH - 1);
                            state <= MUL;
                        end
`endif
                    end
                end
                EXEC: begin
                    result    <= alu_res;
                    carry     <= alu_c;
                    zero      <= (alu_res == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                MUL: begin
`ifdef ULA_MUL_EN
                    acc <= acc_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result    <= acc_step[WIDTH-1:0];
                        carry     <= |acc_step[2*WIDTH-1:WIDTH];
                        zero      <= (acc_step[WIDTH-1:0] == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
`else
                    state <= IDLE;
                    in_ready <= 1'b1;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
